// File: rtl/mac_timestep_scheduler.sv
// mac_timestep_scheduler
// Sequencer and round-robin spike arbiter for one MAC unit.
//   After reset, set is pulsed for SET_CYCLES cycles. The block then runs timesteps of exactly
//   TIMESTEP_CYCLES cycles, and the last cycle of each is a one-cycle clear. During the grant
//   window of a timestep, NUM_REQ valid/ready spike channels are merged round-robin onto
//   source_address, one address per cycle.
// Ports:
//   CLK, RST        clock / asynchronous active-high reset
//   req_valid       per-channel spike pending
//   req_addr        per-channel address, channel i at [i*ADDR_W +: ADDR_W]
//   req_ready       one-hot combinational grant
//   source_address  registered granted address (IDLE_ADDR when nothing is granted)
//   addr_valid      source_address carries a granted spike
//   set / clear     MAC initialisation strobe / end-of-timestep strobe
//   timestep_count  completed timesteps (wraps)
//   spike_count     spikes in the last completed timestep (only with SPIKE_CNT_EN)
// Optional feature macro: SPIKE_CNT_EN
module mac_timestep_scheduler #(
   parameter int NUM_REQ         = 4,
   parameter int ADDR_W          = 12,
   parameter int TIMESTEP_CYCLES = 16,
   parameter int SET_CYCLES      = 2,
   parameter logic [ADDR_W-1:0] IDLE_ADDR = {ADDR_W{1'b1}}
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [ADDR_W-1:0]         source_address,
   output logic                      addr_valid,
   output logic                      set,
   output logic                      clear,
`ifdef SPIKE_CNT_EN
   output logic [15:0]               spike_count,
`endif
   output logic [15:0]               timestep_count
);

   localparam int PTR_W   = $clog2(NUM_REQ);
   localparam int CNT_MAX = (TIMESTEP_CYCLES > SET_CYCLES) ? TIMESTEP_CYCLES : SET_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] LAST_RUN   = CNT_W'(TIMESTEP_CYCLES - 2);
   localparam logic [CNT_W-1:0] LAST_GRANT = CNT_W'(TIMESTEP_CYCLES - 3);
   localparam logic [CNT_W-1:0] SET_LEN    = CNT_W'(SET_CYCLES);

   typedef enum logic [1:0] {INIT, RUN, CLEAR} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   win;
   logic               found;
   logic               window;
   logic               handshake;
   logic [ADDR_W-1:0]  grant_addr;
   logic [PTR_W-1:0]   ptr_next;

   // Rotating priority search starting at ptr; first valid channel wins.
   always_comb begin : arb
      int idx;
      idx   = 0;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = PTR_W'(idx);
         end
      end
   end

   // The last RUN cycle is kept grant-free so a granted address can never land on clear.
   assign window     = (state == RUN) && (cnt <= LAST_GRANT);
   assign handshake  = found && window;
   assign req_ready  = handshake ? (NUM_REQ'(1) << win) : '0;
   assign grant_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];
   assign ptr_next   = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;

`ifdef SPIKE_CNT_EN
   logic [15:0] spike_acc;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state          <= INIT;
         cnt            <= '0;
         ptr            <= '0;
         source_address <= IDLE_ADDR;
         addr_valid     <= 1'b0;
         set            <= 1'b0;
         clear          <= 1'b0;
         timestep_count <= '0;
`ifdef SPIKE_CNT_EN
         spike_acc      <= '0;
         spike_count    <= '0;
`endif
      end else begin
         if (handshake) begin
            source_address <= grant_addr;
            addr_valid     <= 1'b1;
            ptr            <= ptr_next;
`ifdef SPIKE_CNT_EN
            if (spike_acc != 16'hFFFF) spike_acc <= spike_acc + 16'd1;
`endif
         end else begin
            source_address <= IDLE_ADDR;
            addr_valid     <= 1'b0;
         end

         case (state)
            INIT: begin
               // cnt counts set cycles; set drops on the same edge RUN begins.
               if (cnt < SET_LEN) begin
                  set <= 1'b1;
                  cnt <= cnt + 1'b1;
               end else begin
                  set   <= 1'b0;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (cnt == LAST_RUN) begin
                  state          <= CLEAR;
                  clear          <= 1'b1;
                  cnt            <= '0;
                  timestep_count <= timestep_count + 16'd1;
`ifdef SPIKE_CNT_EN
                  // No handshake is possible on this cycle, so spike_acc is final here.
                  spike_count    <= spike_acc;
                  spike_acc      <= '0;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CLEAR: begin
               clear <= 1'b0;
               cnt   <= '0;
               state <= RUN;
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_timestep_scheduler.sv
module tb_mac_timestep_scheduler;

   logic        CLK;
   logic        RST;
   logic [3:0]  req_valid;
   logic [47:0] req_addr;
   logic [3:0]  req_ready;
   logic [11:0] source_address;
   logic        addr_valid;
   logic        set;
   logic        clear;
   logic [15:0] timestep_count;
`ifdef SPIKE_CNT_EN
   logic [15:0] spike_count;
`endif

   int errors = 0;
   int checks = 0;
   logic [11:0] exp_q[$];
   logic [11:0] mon_exp;

   mac_timestep_scheduler dut (
      .CLK            (CLK),
      .RST            (RST),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .req_ready      (req_ready),
      .source_address (source_address),
      .addr_valid     (addr_valid),
      .set            (set),
      .clear          (clear),
`ifdef SPIKE_CNT_EN
      .spike_count    (spike_count),
`endif
      .timestep_count (timestep_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard: every granted address must match the next expected one.
   always @(negedge CLK) begin
      if (!RST) begin
         checks++;
         if (clear && (addr_valid || set)) begin
            errors++;
            $display("FAIL strobe_excl: clear=%b addr_valid=%b set=%b", clear, addr_valid, set);
         end
         if (addr_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_grant: got addr %0d, expected no grant", source_address);
            end else begin
               mon_exp = exp_q.pop_front();
               if (source_address !== mon_exp) begin
                  errors++;
                  $display("FAIL grant_addr: got %0d, expected %0d", source_address, mon_exp);
               end
            end
         end
      end
   end

   task automatic set_addr(input int ch, input logic [11:0] a);
      req_addr[ch*12 +: 12] = a;
   endtask

   // Leaves the caller at the negedge of a clear cycle.
   task automatic sync_clear();
      bit found = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (clear === 1'b1) begin
            found = 1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL sync_clear: no clear within 40 cycles");
      end
   endtask

   task automatic check_set_pulse(input string name);
      for (int k = 1; k <= 40; k++) begin
         @(negedge CLK);
         checks++;
         if (set !== (k <= 2)) begin
            errors++;
            $display("FAIL %s_set k=%0d: got %b, expected %b", name, k, set, (k <= 2));
         end
         checks++;
         if (clear !== (k == 18 || k == 34)) begin
            errors++;
            $display("FAIL %s_clear k=%0d: got %b, expected %b", name, k, clear, (k == 18 || k == 34));
         end
         if (k == 17 || k == 19 || k == 35) begin
            checks++;
            if (timestep_count !== ((k == 17) ? 16'd0 : (k == 19) ? 16'd1 : 16'd2)) begin
               errors++;
               $display("FAIL %s_tscount k=%0d: got %0d", name, k, timestep_count);
            end
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      req_valid = 4'hF;
      for (int i = 0; i < 4; i++) set_addr(i, 12'(13 + i));
      repeat (2) @(negedge CLK);
      checks++;
      if (req_ready !== 4'h0) begin errors++; $display("FAIL rst_ready: got %b, expected 0000", req_ready); end
      checks++;
      if (source_address !== 12'hFFF) begin errors++; $display("FAIL rst_addr: got %h, expected fff", source_address); end
      checks++;
      if ({addr_valid, set, clear} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b, expected 000", {addr_valid, set, clear}); end
      checks++;
      if (timestep_count !== 16'd0) begin errors++; $display("FAIL rst_tscount: got %0d, expected 0", timestep_count); end
`ifdef SPIKE_CNT_EN
      checks++;
      if (spike_count !== 16'd0) begin errors++; $display("FAIL rst_spike: got %0d, expected 0", spike_count); end
`endif
      req_valid = 4'h0;
      RST = 1'b0;
      check_set_pulse("reset");
   endtask

   task automatic test_back_to_back();
      logic [3:0] e;
      sync_clear();
      req_valid = 4'hF;
      for (int i = 0; i < 4; i++) set_addr(i, 12'(13 + i));
      exp_q.push_back(12'd13); exp_q.push_back(12'd14); exp_q.push_back(12'd15);
      exp_q.push_back(12'd16); exp_q.push_back(12'd13);
      #1;
      checks++;
      if (req_ready !== 4'h0) begin errors++; $display("FAIL b2b_clear_ready: got %b, expected 0000", req_ready); end
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         e = 4'b0001 << (k % 4);
         checks++;
         if (req_ready !== e) begin errors++; $display("FAIL b2b_ready k=%0d: got %b, expected %b", k, req_ready, e); end
      end
      @(posedge CLK); #1;
      req_valid = 4'h0;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_single();
      sync_clear();
      req_valid = 4'b0001;
      set_addr(0, 12'd13);
      exp_q.push_back(12'd13);
      #1;
      checks++;
      if (req_ready !== 4'h0) begin errors++; $display("FAIL single_clear_ready: got %b, expected 0000", req_ready); end
      @(negedge CLK);
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b, expected 0001", req_ready); end
      @(posedge CLK); #1;
      req_valid = 4'h0;
      @(negedge CLK);
      checks++;
      if (addr_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b, expected 1", addr_valid); end
      @(negedge CLK);
      checks++;
      if ({addr_valid, source_address} !== {1'b0, 12'hFFF}) begin
         errors++; $display("FAIL single_idle: got %b/%h, expected 0/fff", addr_valid, source_address);
      end
   endtask

   task automatic test_last_run();
      sync_clear();
      repeat (15) @(negedge CLK);
      req_valid = 4'b0100;
      set_addr(2, 12'd15);
      exp_q.push_back(12'd15);
      #1;
      checks++;
      if (req_ready !== 4'h0) begin errors++; $display("FAIL last_run_ready: got %b, expected 0000", req_ready); end
      @(negedge CLK);
      checks++;
      if ({clear, req_ready} !== 5'b1_0000) begin errors++; $display("FAIL last_clear: got clear=%b ready=%b, expected 1/0000", clear, req_ready); end
      @(negedge CLK);
      checks++;
      if ({clear, req_ready} !== 5'b0_0100) begin errors++; $display("FAIL last_next_ready: got clear=%b ready=%b, expected 0/0100", clear, req_ready); end
      @(posedge CLK); #1;
      req_valid = 4'h0;
      @(negedge CLK);
      checks++;
      if (addr_valid !== 1'b1) begin errors++; $display("FAIL last_valid: got %b, expected 1", addr_valid); end
   endtask

   task automatic test_reset_mid();
      sync_clear();
      req_valid = 4'b1010;
      set_addr(1, 12'd21);
      set_addr(3, 12'd23);
      exp_q.push_back(12'd23);
      @(negedge CLK);
      checks++;
      if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_ready: got %b, expected 1000", req_ready); end
      @(posedge CLK); #1;
      req_valid = 4'b0010;
      @(negedge CLK);
      #2;
      RST = 1'b1;
      #1;
      checks++;
      if ({addr_valid, source_address} !== {1'b0, 12'hFFF}) begin
         errors++; $display("FAIL mid_rst_addr: got %b/%h, expected 0/fff", addr_valid, source_address);
      end
      checks++;
      if (req_ready !== 4'h0) begin errors++; $display("FAIL mid_rst_ready: got %b, expected 0000", req_ready); end
      checks++;
      if ({set, clear, timestep_count} !== 18'd0) begin
         errors++; $display("FAIL mid_rst_ctl: got set=%b clear=%b ts=%0d, expected 0/0/0", set, clear, timestep_count);
      end
      req_valid = 4'h0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      check_set_pulse("rerun");
   endtask

`ifdef SPIKE_CNT_EN
   task automatic test_spike_count();
      sync_clear();
      req_valid = 4'b0001;
      set_addr(0, 12'd13);
      for (int k = 0; k < 5; k++) exp_q.push_back(12'd13);
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         checks++;
         if (req_ready !== 4'b0001) begin errors++; $display("FAIL spike_ready k=%0d: got %b, expected 0001", k, req_ready); end
      end
      @(posedge CLK); #1;
      req_valid = 4'h0;
      sync_clear();
      checks++;
      if (spike_count !== 16'd5) begin errors++; $display("FAIL spike_five: got %0d, expected 5", spike_count); end
      sync_clear();
      checks++;
      if (spike_count !== 16'd0) begin errors++; $display("FAIL spike_zero: got %0d, expected 0", spike_count); end
   endtask
`endif

   initial begin
      RST = 1'b1;
      req_valid = 4'h0;
      req_addr = '0;
      test_reset();
      test_back_to_back();
      test_single();
      test_last_run();
      test_reset_mid();
`ifdef SPIKE_CNT_EN
      test_spike_count();
`endif
      repeat (2) @(negedge CLK);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: %0d expected grants never appeared", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
